// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline constants and the skid stage state encoding.
// Type/constant definitions only; no latency or backpressure of its own.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int MEM_WB_DATA_W = 128;
  localparam int MEM_WB_CTRL_W = 8;

  function automatic logic [1:0] state_occupancy(input skid_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_entry.sv
// One skid storage slot: payload+control register with load, clear-to-default and valid bit.
// Updates one cycle after ld/clr/inval; no backpressure, the owner sequences it.
module skid_entry #(
  parameter int                 DATA_W       = 128,
  parameter int                 CTRL_W       = 8,
  parameter logic [CTRL_W-1:0]  CTRL_DEFAULT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic              inval,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    vld_d  = vld_q;
    if (clr) begin
      data_d = '0;
      ctrl_d = CTRL_DEFAULT;
      vld_d  = 1'b0;
    end else if (ld) begin
      data_d = ld_data;
      ctrl_d = ld_ctrl;
      vld_d  = 1'b1;
    end else if (inval) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= CTRL_DEFAULT;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      vld_q  <= vld_d;
    end
  end

  assign data = data_q;
  // An invalid slot never presents live control, so a drained stage cannot write a register.
  assign ctrl = vld_q ? ctrl_q : CTRL_DEFAULT;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register (MEM/WB by default) with stall and flush; 1-cycle latency.
// Backpressure: in_ready is low when both entries are held or stall is high, independent of out_ready.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                DATA_W       = MEM_WB_DATA_W,
  parameter int                CTRL_W       = MEM_WB_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_DEFAULT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  skid_state_e state_q, state_d;
  logic enq, deq;
  logic main_ld, main_from_skid, main_inval;
  logic skid_ld, skid_inval;
  logic [DATA_W-1:0] main_ld_data, skid_data;
  logic [CTRL_W-1:0] main_ld_ctrl, skid_ctrl;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  assign in_ready  = (state_q != ST_FULL) & ~stall;
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_occupancy(state_q);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready & ~stall;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (!stall) begin
      case (state_q)
        ST_EMPTY: if (enq) state_d = ST_ONE;
        ST_ONE: begin
          if (enq && !deq)      state_d = ST_FULL;
          else if (!enq && deq) state_d = ST_EMPTY;
        end
        ST_FULL:  if (deq) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    main_inval     = 1'b0;
    skid_ld        = 1'b0;
    skid_inval     = 1'b0;
    if (!flush && !stall) begin
      case (state_q)
        ST_EMPTY: main_ld = enq;
        ST_ONE: begin
          main_ld    = enq & deq;
          skid_ld    = enq & ~deq;
          main_inval = ~enq & deq;
        end
        ST_FULL: begin
          main_ld        = deq;
          main_from_skid = deq;
          skid_inval     = deq;
        end
        default: main_inval = 1'b1;
      endcase
    end
  end

  assign main_ld_data = main_from_skid ? skid_data : in_data;
  assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  skid_entry #(
    .DATA_W       (DATA_W),
    .CTRL_W       (CTRL_W),
    .CTRL_DEFAULT (CTRL_DEFAULT)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .ld      (main_ld),
    .inval   (main_inval),
    .ld_data (main_ld_data),
    .ld_ctrl (main_ld_ctrl),
    .data    (out_data),
    .ctrl    (out_ctrl)
  );

  skid_entry #(
    .DATA_W       (DATA_W),
    .CTRL_W       (CTRL_W),
    .CTRL_DEFAULT (CTRL_DEFAULT)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .ld      (skid_ld),
    .inval   (skid_inval),
    .ld_data (in_data),
    .ld_ctrl (in_ctrl),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a long random run against a queue model.
module tb_pipe_skid_reg;

  localparam int DW = 128;
  localparam int CW = 8;
  localparam logic [CW-1:0] CDEF = 8'h00;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    occupancy;

  pipe_skid_reg #(
    .DATA_W       (DW),
    .CTRL_W       (CW),
    .CTRL_DEFAULT (CDEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall     (stall),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t q[$];
  bit   synced    = 0;
  bit   data_zero = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  bit   last_acc  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare against the queue model, then advance model and DUT.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic st, input logic fl, input logic r);
    bit m_rdy;
    bit m_vld;
    ent_t e;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    rst       = r;
    #1;
    m_rdy = (q.size() < 2) && !st;
    m_vld = (q.size() > 0);
    if (synced) begin
      chk("in_ready", DW'(in_ready), DW'(m_rdy));
      chk("out_valid", DW'(out_valid), DW'(m_vld));
      chk("occupancy", DW'(occupancy), DW'(q.size()));
      chk("out_ctrl", DW'(out_ctrl), DW'(m_vld ? q[0].c : CDEF));
      if (m_vld) chk("out_data", out_data, q[0].d);
      else if (data_zero) chk("out_data_zero", out_data, '0);
    end
    @(posedge clk);
    last_acc = 0;
    if (r || fl) begin
      q.delete();
      data_zero = 1;
    end else if (!st) begin
      if (m_vld && ordy) void'(q.pop_front());
      if (iv && m_rdy) begin
        e.d = d;
        e.c = c;
        q.push_back(e);
        data_zero = 0;
        last_acc = 1;
      end
    end
    if (r) synced = 1;
    @(negedge clk);
  endtask

  task automatic idle_reset();
    step(0, '0, '0, 0, 0, 0, 1);
  endtask

  initial begin
    logic          cv;
    logic [DW-1:0] cd;
    logic [CW-1:0] cc;
    @(negedge clk);

    // Reset values.
    idle_reset();
    chk("rst_occ", DW'(occupancy), 0);
    chk("rst_vld", DW'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_ctrl", DW'(out_ctrl), DW'(CDEF));
    chk("rst_rdy", DW'(in_ready), 1);

    // Streaming with out_ready high: one-cycle latency, occupancy steady at 1.
    for (int i = 0; i < 4; i++) step(1, 128'h1, 8'h11, 1, 0, 0, 0);
    chk("stream_vld", DW'(out_valid), 1);
    chk("stream_data", out_data, 128'h1);
    chk("stream_occ", DW'(occupancy), 1);

    // Backpressure: A then B fill both entries, third word waits.
    idle_reset();
    step(1, 128'hA, 8'h0A, 0, 0, 0, 0);
    chk("bp_occ1", DW'(occupancy), 1);
    step(1, 128'hB, 8'h0B, 0, 0, 0, 0);
    chk("bp_occ2", DW'(occupancy), 2);
    chk("bp_rdy", DW'(in_ready), 0);
    chk("bp_head", out_data, 128'hA);
    step(1, 128'hE, 8'h0E, 1, 0, 0, 0);
    chk("bp_second", out_data, 128'hB);
    chk("bp_no_early", DW'(occupancy), 1);
    step(0, '0, '0, 1, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0, 0);

    // Stall from FULL holds everything for three cycles.
    idle_reset();
    step(1, 128'hC, 8'h0C, 0, 0, 0, 0);
    step(1, 128'hD, 8'h0D, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 128'hF, 8'h0F, 1, 1, 0, 0);
      chk("stall_data", out_data, 128'hC);
      chk("stall_occ", DW'(occupancy), 2);
    end
    step(0, '0, '0, 1, 0, 0, 0);
    chk("unstall_d", out_data, 128'hD);
    step(0, '0, '0, 1, 0, 0, 0);

    // Flush from FULL drops both entries and the concurrent input.
    step(1, 128'h21, 8'h21, 0, 0, 0, 0);
    step(1, 128'h22, 8'h22, 0, 0, 0, 0);
    step(1, 128'h23, 8'h23, 0, 0, 1, 0);
    chk("flush_occ", DW'(occupancy), 0);
    chk("flush_vld", DW'(out_valid), 0);
    chk("flush_ctrl", DW'(out_ctrl), DW'(CDEF));
    chk("flush_data", out_data, 0);

    // Reset while ONE with all-ones control.
    step(1, 128'h55, 8'hFF, 0, 0, 0, 0);
    chk("pre_rst_ctrl", DW'(out_ctrl), 128'hFF);
    idle_reset();
    chk("mid_rst_ctrl", DW'(out_ctrl), 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_vld", DW'(out_valid), 0);

    // Random run; upstream keeps an unaccepted word stable.
    cv = 0;
    cd = '0;
    cc = '0;
    for (int i = 0; i < 10000; i++) begin
      logic st, fl, r, ordy;
      if (!cv || last_acc || i == 0) begin
        cv = ($urandom_range(0, 9) < 6);
        cd = {$urandom, $urandom, $urandom, $urandom};
        cc = 8'($urandom);
      end
      ordy = ($urandom_range(0, 9) < 6);
      st   = ($urandom_range(0, 4) == 0);
      fl   = ($urandom_range(0, 49) == 0);
      r    = ($urandom_range(0, 499) == 0);
      step(cv, cd, cc, ordy, st, fl, r);
      if (fl || r) cv = 0;
      if (i % 64 == 0) chk("occ_max", DW'(occupancy <= 2'd2), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
